// File: rtl/pc_ras.sv
// rtl/pc_ras.sv - program counter with a circular return-address stack
module pc_ras #(
    parameter int               WIDTH        = 8,
    parameter int               RAS_DEPTH    = 4,
    parameter logic [WIDTH-1:0] RESET_VECTOR = '0
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             stall,
    input  logic             branch_en,
    input  logic             call_en,
    input  logic             ret_en,
    input  logic [WIDTH-1:0] branch_target,
    input  logic             clear_err,
    output logic [WIDTH-1:0] instruction_pointer,
    output logic             ras_empty,
    output logic             ras_full,
    output logic             ras_overflow,
    output logic             ras_underflow
);

    localparam int SPW = $clog2(RAS_DEPTH);
    localparam int CW  = $clog2(RAS_DEPTH + 1);

    logic [WIDTH-1:0] ras [RAS_DEPTH];
    logic [SPW-1:0]   sp;
    logic [CW-1:0]    count;
    logic [WIDTH-1:0] ip;
    logic             ovf;
    logic             unf;

    logic [WIDTH-1:0] ip_inc;
    logic [WIDTH-1:0] ip_next;
    logic [WIDTH-1:0] top;
    logic             empty;
    logic             full;
    logic             push;
    logic             pop;
    logic             ret_empty;

    assign empty  = (count == '0);
    assign full   = (count == CW'(RAS_DEPTH));
    assign ip_inc = ip + WIDTH'(1);
    assign top    = ras[sp - SPW'(1)];

    // Only the highest-priority active control may touch the stack.
    always_comb begin
        push      = 1'b0;
        pop       = 1'b0;
        ret_empty = 1'b0;
        ip_next   = ip_inc;
        if (stall) begin
            ip_next = ip;
        end else if (ret_en) begin
            if (empty) begin
                ret_empty = 1'b1;
            end else begin
                pop     = 1'b1;
                ip_next = top;
            end
        end else if (call_en) begin
            push    = 1'b1;
            ip_next = branch_target;
        end else if (branch_en) begin
            ip_next = branch_target;
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            ip    <= RESET_VECTOR;
            sp    <= '0;
            count <= '0;
            ovf   <= 1'b0;
            unf   <= 1'b0;
        end else begin
            ip <= ip_next;
            if (push) begin
                sp <= sp + SPW'(1);
                if (!full) begin
                    count <= count + CW'(1);
                end
            end else if (pop) begin
                sp    <= sp - SPW'(1);
                count <= count - CW'(1);
            end
            // A new event in the same cycle as clear_err keeps the flag set.
            if (push && full) begin
                ovf <= 1'b1;
            end else if (clear_err) begin
                ovf <= 1'b0;
            end
            if (ret_empty) begin
                unf <= 1'b1;
            end else if (clear_err) begin
                unf <= 1'b0;
            end
        end
    end

    // Stack entries carry no reset; a push when full overwrites the oldest slot.
    always_ff @(posedge clk) begin
        if (push) begin
            ras[sp] <= ip_inc;
        end
    end

    assign instruction_pointer = ip;
    assign ras_empty           = empty;
    assign ras_full            = full;
    assign ras_overflow        = ovf;
    assign ras_underflow       = unf;

endmodule

// File: tb/tb_pc_ras.sv
// tb/tb_pc_ras.sv - directed self-checking bench for pc_ras
module tb_pc_ras;

    logic       clk = 1'b0;
    logic       rst;
    logic       stall;
    logic       branch_en;
    logic       call_en;
    logic       ret_en;
    logic [7:0] branch_target;
    logic       clear_err;
    logic [7:0] instruction_pointer;
    logic       ras_empty;
    logic       ras_full;
    logic       ras_overflow;
    logic       ras_underflow;

    int errors = 0;
    int checks = 0;

    pc_ras #(.WIDTH(8), .RAS_DEPTH(4), .RESET_VECTOR(8'h00)) dut (
        .clk                 (clk),
        .rst                 (rst),
        .stall               (stall),
        .branch_en           (branch_en),
        .call_en             (call_en),
        .ret_en              (ret_en),
        .branch_target       (branch_target),
        .clear_err           (clear_err),
        .instruction_pointer (instruction_pointer),
        .ras_empty           (ras_empty),
        .ras_full            (ras_full),
        .ras_overflow        (ras_overflow),
        .ras_underflow       (ras_underflow)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic idle();
        stall = 0; branch_en = 0; call_en = 0; ret_en = 0; clear_err = 0;
    endtask

    task automatic flags(input string tag, input logic e, input logic f,
                         input logic o, input logic u);
        chk({tag, "_empty"}, {31'd0, ras_empty}, {31'd0, e});
        chk({tag, "_full"},  {31'd0, ras_full},  {31'd0, f});
        chk({tag, "_ovf"},   {31'd0, ras_overflow},  {31'd0, o});
        chk({tag, "_unf"},   {31'd0, ras_underflow}, {31'd0, u});
    endtask

    logic [7:0] call_tgt [5];
    logic [7:0] ret_exp  [4];

    initial begin
        call_tgt[0] = 8'h20; call_tgt[1] = 8'h30; call_tgt[2] = 8'h40;
        call_tgt[3] = 8'h50; call_tgt[4] = 8'h60;
        ret_exp[0] = 8'h51; ret_exp[1] = 8'h41; ret_exp[2] = 8'h31; ret_exp[3] = 8'h21;

        rst = 0; branch_target = 8'h00;
        idle();
        step(); step();
        chk("reset_ip", {24'd0, instruction_pointer}, 32'h00);
        flags("reset", 1, 0, 0, 0);
        rst = 1;
        for (int i = 1; i <= 5; i++) begin
            step();
            chk("incr_ip", {24'd0, instruction_pointer}, i);
        end

        // asynchronous reset between edges
        #2 rst = 0;
        #1 chk("async_rst_ip", {24'd0, instruction_pointer}, 32'h00);
        rst = 1;
        step();
        chk("post_rst_ip", {24'd0, instruction_pointer}, 32'h01);

        // branch and wrap
        branch_en = 1; branch_target = 8'hFE;
        step(); idle();
        chk("branch_fe", {24'd0, instruction_pointer}, 32'hFE);
        step(); chk("wrap_ff", {24'd0, instruction_pointer}, 32'hFF);
        step(); chk("wrap_00", {24'd0, instruction_pointer}, 32'h00);
        step(); chk("wrap_01", {24'd0, instruction_pointer}, 32'h01);
        flags("wrap", 1, 0, 0, 0);

        // nested call/return
        branch_en = 1; branch_target = 8'h10; step(); idle();
        chk("nest_start", {24'd0, instruction_pointer}, 32'h10);
        call_en = 1; branch_target = 8'h40; step(); idle();
        chk("nest_call1", {24'd0, instruction_pointer}, 32'h40);
        chk("nest_nonempty", {31'd0, ras_empty}, 32'd0);
        step(); chk("nest_inc", {24'd0, instruction_pointer}, 32'h41);
        call_en = 1; branch_target = 8'h80; step(); idle();
        chk("nest_call2", {24'd0, instruction_pointer}, 32'h80);
        ret_en = 1; step();
        chk("nest_ret1", {24'd0, instruction_pointer}, 32'h42);
        step(); idle();
        chk("nest_ret2", {24'd0, instruction_pointer}, 32'h11);
        flags("nest", 1, 0, 0, 0);

        // overflow: five calls into a four-deep stack
        branch_en = 1; branch_target = 8'h00; step(); idle();
        chk("ovf_start", {24'd0, instruction_pointer}, 32'h00);
        for (int i = 0; i < 5; i++) begin
            call_en = 1; branch_target = call_tgt[i]; step(); idle();
            chk("ovf_call_ip", {24'd0, instruction_pointer}, {24'd0, call_tgt[i]});
            if (i == 3) flags("ovf_fill", 0, 1, 0, 0);
        end
        flags("ovf_set", 0, 1, 1, 0);
        for (int i = 0; i < 4; i++) begin
            ret_en = 1; step(); idle();
            chk("ovf_ret_ip", {24'd0, instruction_pointer}, {24'd0, ret_exp[i]});
        end
        flags("ovf_drained", 1, 0, 1, 0);
        clear_err = 1; step(); idle();
        chk("ovf_clear", {31'd0, ras_overflow}, 32'd0);

        // underflow, clear, set-wins-over-clear
        branch_en = 1; branch_target = 8'h07; step(); idle();
        ret_en = 1; step(); idle();
        chk("unf_ip", {24'd0, instruction_pointer}, 32'h08);
        flags("unf_set", 1, 0, 0, 1);
        clear_err = 1; step(); idle();
        chk("unf_clear_ip", {24'd0, instruction_pointer}, 32'h09);
        chk("unf_clear", {31'd0, ras_underflow}, 32'd0);
        ret_en = 1; clear_err = 1; step(); idle();
        chk("unf_set_wins", {31'd0, ras_underflow}, 32'd1);
        stall = 1; clear_err = 1; step(); idle();
        chk("stall_clear_ip", {24'd0, instruction_pointer}, 32'h0A);
        chk("stall_clear_unf", {31'd0, ras_underflow}, 32'd0);

        // pushed return address wraps
        branch_en = 1; branch_target = 8'hFF; step(); idle();
        call_en = 1; branch_target = 8'h10; step(); idle();
        chk("wrap_call_ip", {24'd0, instruction_pointer}, 32'h10);
        ret_en = 1; step(); idle();
        chk("wrap_ret_ip", {24'd0, instruction_pointer}, 32'h00);

        // priority: stall over everything, ret over call
        branch_en = 1; branch_target = 8'h32; step(); idle();
        call_en = 1; branch_target = 8'h50; step(); idle();
        chk("prio_call_ip", {24'd0, instruction_pointer}, 32'h50);
        stall = 1; ret_en = 1; call_en = 1; branch_en = 1; branch_target = 8'h77;
        step(); idle();
        chk("prio_stall_ip", {24'd0, instruction_pointer}, 32'h50);
        flags("prio_stall", 0, 0, 0, 0);
        ret_en = 1; call_en = 1; branch_target = 8'h77; step(); idle();
        chk("prio_ret_ip", {24'd0, instruction_pointer}, 32'h33);
        flags("prio_ret", 1, 0, 0, 0);
        step();
        chk("prio_after_ip", {24'd0, instruction_pointer}, 32'h34);
        chk("prio_after_empty", {31'd0, ras_empty}, 32'd1);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
